addsub_seq32: RTL



---
 rtl/addsub_seq_pkg.sv | 15 +
 rtl/adder_8bit.sv | 24 ++
 rtl/addsub_seq32.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/addsub_seq_pkg.sv
// Shared constants for the sequential add/subtract unit: FSM encoding, slice width, mode codes.
package addsub_seq_pkg;

    localparam int SLICE_W = 8;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_8bit.sv
// 8-bit ripple-carry adder slice used as the shared datapath of addsub_seq32.
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);

    logic [8:0] w_carry;

    always_comb begin
        w_carry    = '0;
        s          = '0;
        w_carry[0] = ci;
        for (int i = 0; i < 8; i++) begin
            s[i]         = a[i] ^ b[i] ^ w_carry[i];
            w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    end

    assign co = w_carry[8];

endmodule

// File: rtl/addsub_seq32.sv
// Multi-cycle add/subtract: one 8-bit slice per cycle, LSB first, with valid/ready on both sides.
// Optional zero flag output z is enabled by defining ADDSUB_SEQ_ZFLAG_EN.
//
//   state | meaning
//   IDLE  | waiting for operands (in_ready=1)
//   RUN   | processing slice r_idx, carry chained through r_carry
//   DONE  | result and flags held until the consumer takes them
module addsub_seq32
    import addsub_seq_pkg::*;
#(
    parameter int N_SLICES = 4,
    parameter int SLICE_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [8*N_SLICES-1:0]      x,
    input  logic [8*N_SLICES-1:0]      y,
    input  logic                       m,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [8*N_SLICES-1:0]      s,
    output logic                       c,
    output logic                       v
`ifdef ADDSUB_SEQ_ZFLAG_EN
    ,
    output logic                       z
`endif
);

    localparam int DATA_W = 8 * N_SLICES;
    localparam int IDX_W  = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

    generate
        if (SLICE_W != addsub_seq_pkg::SLICE_W) begin : g_bad_slice_w
            $error("addsub_seq32: SLICE_W must be 8 to match adder_8bit");
        end
        if (N_SLICES < 1 || N_SLICES > 8) begin : g_bad_n_slices
            $error("addsub_seq32: N_SLICES must be in 1..8");
        end
    endgenerate

    state_t r_state;
    state_t w_state_next;

    logic [N_SLICES-1:0][7:0] r_a;
    logic [N_SLICES-1:0][7:0] r_b;
    logic [N_SLICES-1:0][7:0] r_s;
    logic [N_SLICES-1:0][7:0] w_s_next;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_carry;
    logic                     r_c;
    logic                     r_v;

    logic [7:0] w_a_slice;
    logic [7:0] w_b_slice;
    logic [7:0] w_sum;
    logic       w_co;
    logic       w_accept;
    logic       w_last;
    logic       w_ovf;

    assign w_a_slice = r_a[r_idx];
    assign w_b_slice = r_b[r_idx];

    adder_8bit u_slice (
        .a  (w_a_slice),
        .b  (w_b_slice),
        .ci (r_carry),
        .s  (w_sum),
        .co (w_co)
    );

    // Merged view of the result with the current slice written in; feeds both r_s and the zero flag.
    always_comb begin
        w_s_next        = r_s;
        w_s_next[r_idx] = w_sum;
    end

    assign w_last = (r_idx == LAST_IDX);
    assign w_ovf  = (w_a_slice[7] == w_b_slice[7]) && (w_sum[7] != w_a_slice[7]);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a     <= x;
                r_b     <= (m == MODE_SUB) ? ~y : y;
                r_carry <= m;
                r_idx   <= '0;
            end else if (r_state == RUN) begin
                r_s     <= w_s_next;
                r_carry <= w_co;
                r_idx   <= r_idx + IDX_W'(1);
                if (w_last) begin
                    r_c <= w_co;
                    r_v <= w_ovf;
                end
            end
        end
    end

`ifdef ADDSUB_SEQ_ZFLAG_EN
    logic r_z;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_z <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_z <= (w_s_next == '0);
        end
    end

    assign z = r_z;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign s         = DATA_W'(r_s);
    assign c         = r_c;
    assign v         = r_v;

endmodule
